pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit.sv | 105 ++++++++++
 tb/tb_pc_fetch_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction fetch sequencer.
// Issues a fetch for pc, latches the returned word, then advances pc once downstream releases stall.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [1:0]  dbg_state
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic        inst_valid_q;
    logic [31:0] next_pc;
    logic [31:0] branch_target;
    logic [31:0] jump_addr;
    logic        capture;
    logic        advance;

    // Handshake: imem_req stays high with a stable imem_addr until the cycle imem_ack is 1;
    // that cycle transfers imem_rdata and the request drops on the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_REQ;
            S_REQ:   if (imem_ack) state_nxt = S_VALID;
            S_VALID: if (!stall)   state_nxt = S_REQ;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req  = (state == S_REQ);
        capture   = (state == S_REQ) && imem_ack;
        advance   = (state == S_VALID) && !stall;
        dbg_state = state;
    end

    assign pc_plus4      = pc_q + 32'd4;
    assign branch_target = pc_plus4 + {branch_offset[29:0], 2'b00};
    assign jump_addr     = {pc_plus4[31:28], jump_target, 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_addr;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end
    end

    // Low bits are forced clear so pc stays word aligned whatever the target arithmetic produced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC_ALIGNED;
            inst_q       <= 32'd0;
            inst_valid_q <= 1'b0;
        end else begin
            if (capture) begin
                inst_q       <= imem_rdata;
                inst_valid_q <= 1'b1;
            end else if (advance) begin
                pc_q         <= {next_pc[31:2], 2'b00};
                inst_valid_q <= 1'b0;
            end
        end
    end

    assign pc         = pc_q;
    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: fetch/advance sequences with a pc/inst scoreboard.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_target;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] inst;
    logic        inst_valid;
    logic [1:0]  dbg_state;

    logic [63:0] exp_q[$];
    logic [31:0] model_pc;
    int          n_checks = 0;
    int          n_pass   = 0;

    pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .inst          (inst),
        .inst_valid    (inst_valid),
        .dbg_state     (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] off_to(input logic [31:0] from_pc, input logic [31:0] target);
        logic [31:0] d;
        d = target - from_pc - 32'd4;
        return {{2{d[31]}}, d[31:2]};
    endfunction

    task automatic wait_req();
        for (int n = 0; n < 20 && !imem_req; n++) @(negedge clk);
        chk("req_timeout", {63'd0, imem_req}, 64'd1);
    endtask

    // Called at a negedge; returns at the negedge where the fetched word should be visible.
    task automatic do_fetch(input int waits, input logic [31:0] data);
        logic [63:0] e;
        wait_req();
        chk("req_addr", {32'd0, imem_addr}, {32'd0, model_pc});
        chk("req_pc_plus4", {32'd0, pc_plus4}, {32'd0, model_pc + 32'd4});
        for (int w = 0; w < waits; w++) begin
            @(negedge clk);
            chk("wait_req", {63'd0, imem_req}, 64'd1);
            chk("wait_addr", {32'd0, imem_addr}, {32'd0, model_pc});
            chk("wait_valid", {63'd0, inst_valid}, 64'd0);
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        exp_q.push_back({model_pc, data});
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        chk("fetch_valid", {63'd0, inst_valid}, 64'd1);
        chk("fetch_req_drop", {63'd0, imem_req}, 64'd0);
        if (exp_q.size() == 0) begin
            chk("sb_empty", 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            chk("fetch_pc", {32'd0, pc}, {32'd0, e[63:32]});
            chk("fetch_inst", {32'd0, inst}, {32'd0, e[31:0]});
        end
    endtask

    // Called in VALID at a negedge; stalls, then advances with the given controls.
    task automatic advance(input int stalls, input logic br, input logic [31:0] off,
                           input logic jmp, input logic [25:0] jt);
        logic [31:0] hold_pc;
        logic [31:0] hold_inst;
        logic [31:0] p4;
        hold_pc   = pc;
        hold_inst = inst;
        for (int i = 0; i < stalls; i++) begin
            stall         = 1'b1;
            branch_taken  = (i == 1);
            jump          = 1'($urandom_range(0, 1));
            jump_target   = 26'($urandom);
            branch_offset = $urandom;
            imem_ack      = 1'($urandom_range(0, 1));
            imem_rdata    = $urandom;
            @(negedge clk);
            chk("stall_pc", {32'd0, pc}, {32'd0, hold_pc});
            chk("stall_inst", {32'd0, inst}, {32'd0, hold_inst});
            chk("stall_valid", {63'd0, inst_valid}, 64'd1);
            chk("stall_req", {63'd0, imem_req}, 64'd0);
        end
        stall         = 1'b0;
        imem_ack      = 1'b0;
        branch_taken  = br;
        branch_offset = off;
        jump          = jmp;
        jump_target   = jt;
        p4 = model_pc + 32'd4;
        if (jmp)     model_pc = {p4[31:28], jt, 2'b00};
        else if (br) model_pc = p4 + (off << 2);
        else         model_pc = p4;
        @(negedge clk);
        branch_taken = 1'b0;
        jump         = 1'b0;
        chk("adv_pc", {32'd0, pc}, {32'd0, model_pc});
        chk("adv_valid", {63'd0, inst_valid}, 64'd0);
        chk("adv_req", {63'd0, imem_req}, 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_offset = 32'd0;
        jump = 1'b0; jump_target = 26'd0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        model_pc = RST_PC;
        repeat (3) @(negedge clk);
        chk("rst_pc", {32'd0, pc}, {32'd0, RST_PC});
        chk("rst_pc_plus4", {32'd0, pc_plus4}, {32'd0, RST_PC + 32'd4});
        chk("rst_req", {63'd0, imem_req}, 64'd0);
        chk("rst_inst", {32'd0, inst}, 64'd0);
        chk("rst_valid", {63'd0, inst_valid}, 64'd0);

        // Release with ack held high: the IDLE cycle must discard it.
        rst_n = 1'b1;
        #1 chk("idle_req", {63'd0, imem_req}, 64'd0);
        @(negedge clk);
        imem_ack = 1'b0;
        chk("first_req", {63'd0, imem_req}, 64'd1);
        chk("first_addr", {32'd0, imem_addr}, {32'd0, RST_PC});
        chk("idle_ack_ignored", {32'd0, inst}, 64'd0);

        do_fetch(2, 32'h2008_0064);
        advance(0, 1'b0, 32'd0, 1'b0, 26'd0);
        chk("seq_pc", {32'd0, pc}, {32'd0, 32'h0040_0004});

        do_fetch(1, $urandom);
        advance(0, 1'b1, off_to(model_pc, 32'h0000_0100), 1'b0, 26'd0);
        chk("br_to_100", {32'd0, pc}, {32'd0, 32'h0000_0100});
        do_fetch(0, $urandom);
        advance(0, 1'b1, 32'hFFFF_FFFE, 1'b0, 26'd0);
        chk("br_back", {32'd0, pc}, {32'd0, 32'h0000_00FC});

        do_fetch(0, $urandom);
        advance(0, 1'b1, off_to(model_pc, 32'h1000_0000), 1'b0, 26'd0);
        do_fetch(1, $urandom);
        advance(0, 1'b1, 32'h0000_0100, 1'b1, 26'h000_0010);
        chk("jump_prio", {32'd0, pc}, {32'd0, 32'h1000_0040});

        do_fetch(0, $urandom);
        advance(3, 1'b0, 32'd0, 1'b0, 26'd0);
        chk("stall_then_seq", {32'd0, pc}, {32'd0, 32'h1000_0044});

        do_fetch(0, $urandom);
        advance(0, 1'b1, off_to(model_pc, 32'hFFFF_FFFC), 1'b0, 26'd0);
        do_fetch(2, $urandom);
        advance(0, 1'b0, 32'd0, 1'b0, 26'd0);
        chk("wrap_zero", {32'd0, pc}, 64'd0);

        for (int t = 0; t < 8; t++) begin
            int mode;
            do_fetch($urandom_range(0, 3), $urandom);
            mode = $urandom_range(0, 2);
            advance($urandom_range(0, 2), mode == 1, 32'($urandom_range(0, 64)) - 32'd32,
                    mode == 2, 26'($urandom));
        end

        // Reset during REQ, ack arriving in the IDLE cycle after release.
        wait_req();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", {63'd0, imem_req}, 64'd0);
        chk("mid_rst_pc", {32'd0, pc}, {32'd0, RST_PC});
        @(negedge clk);
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("restart_valid", {63'd0, inst_valid}, 64'd0);
        chk("restart_inst", {32'd0, inst}, 64'd0);
        chk("restart_addr", {32'd0, imem_addr}, {32'd0, RST_PC});
        @(negedge clk);
        chk("restart_still_req", {63'd0, imem_req}, 64'd1);
        model_pc = RST_PC;
        do_fetch(1, $urandom);

        // Reset during VALID clears the held instruction immediately.
        rst_n = 1'b0;
        #1;
        chk("valid_rst_valid", {63'd0, inst_valid}, 64'd0);
        chk("valid_rst_inst", {32'd0, inst}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_pc = RST_PC;
        do_fetch(0, $urandom);
        advance(1, 1'b0, 32'd0, 1'b0, 26'd0);

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
